// File: rtl/da_fir_pkg.sv
// Shared types and helpers for the DA-FIR streaming stages.
package da_fir_pkg;

    // Feeder sequencing states: wait for work, pulse start, wait for the FIR.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } feeder_state_t;

    // Bits needed for a counter that must hold every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/da_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; DEPTH must be a power of 2.
module da_sample_fifo
    import da_fir_pkg::*;
#(
    parameter int OPSIZE = 12,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [OPSIZE-1:0]             push_data,
    input  logic                          pop,
    output logic [OPSIZE-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [OPSIZE-1:0] mem_q [DEPTH];
    logic [OPSIZE-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push is refused whenever full, even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for storage, pointers (natural power-of-2 wrap) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/da_fir_feeder.sv
// Streaming front-end for DA_fir: input FIFO, one-at-a-time start/ready
// sequencing, watchdog and a single-entry output register.
module da_fir_feeder
    import da_fir_pkg::*;
#(
    parameter int OPSIZE  = 12,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPSIZE-1:0] in_data,
    output logic              fir_start,
    output logic [OPSIZE-1:0] fir_xin,
    input  logic              fir_ready,
    input  logic [OPSIZE-1:0] fir_yout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPSIZE-1:0] out_data,
    output logic              err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and data is held while valid && !ready.

    localparam int WW = cnt_width(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    feeder_state_t     state_q, state_d;
    logic              start_q, start_d;
    logic [OPSIZE-1:0] xin_q, xin_d;
    logic              out_valid_q, out_valid_d;
    logic [OPSIZE-1:0] out_data_q, out_data_d;
    logic              err_q, err_d;
    logic [WW-1:0]     wd_q, wd_d;

    logic                        fifo_pop;
    logic [OPSIZE-1:0]           fifo_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [cnt_width(DEPTH)-1:0] fifo_count_unused;
    logic                        slot_free;
    logic                        capture;

    assign in_ready  = !fifo_full;
    assign fir_start = start_q;
    assign fir_xin   = xin_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

    // Only one sample is ever in flight, so a free slot at issue time
    // guarantees the result register is free when that result returns.
    assign slot_free = !out_valid_q || out_ready;

    da_sample_fifo #(
        .OPSIZE (OPSIZE),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    // Sequencer, watchdog and output-slot next-state logic.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        xin_d       = xin_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        wd_d        = wd_q;
        fifo_pop    = 1'b0;
        capture     = 1'b0;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                // An X fir_ready falls into the not-ready path.
                if (!fifo_empty && fir_ready && slot_free) begin
                    fifo_pop = 1'b1;
                    xin_d    = fifo_data;
                    start_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // fir_ready is still high from idle here, so it is ignored.
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fir_ready) begin
                    capture    = 1'b1;
                    out_data_d = fir_yout;
                    state_d    = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    // Give up on this sample; keep serving the queue.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and datapath registers; reset abandons any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            xin_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            xin_q       <= xin_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

endmodule

// File: tb/tb_da_fir_feeder.sv
// Directed bench for da_fir_feeder with a behavioural L=5 FIR stub
// (yout = xin + 1) and a queue-based output scoreboard.
module tb_da_fir_feeder;

    localparam int OPSIZE  = 12;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [OPSIZE-1:0] in_data;
    logic              fir_start;
    logic [OPSIZE-1:0] fir_xin;
    logic              fir_ready;
    logic [OPSIZE-1:0] fir_yout;
    logic              out_valid;
    logic              out_ready;
    logic [OPSIZE-1:0] out_data;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [OPSIZE-1:0] exp_q[$];

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    da_fir_feeder #(
        .OPSIZE  (OPSIZE),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .fir_start (fir_start),
        .fir_xin   (fir_xin),
        .fir_ready (fir_ready),
        .fir_yout  (fir_yout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIR stub: ready drops on the start edge and returns 5 edges later.
    logic hang;
    logic stub_kick;
    int   stub_cnt;
    always @(posedge clk) begin
        if (rst) begin
            fir_ready <= 1'b1;
            fir_yout  <= '0;
            stub_cnt  <= 0;
        end else if (stub_kick) begin
            fir_ready <= 1'b1;
            stub_cnt  <= 0;
        end else if (fir_start) begin
            fir_ready <= 1'b0;
            stub_cnt  <= 5;
            fir_yout  <= fir_xin + 12'd1;
        end else if (stub_cnt > 0 && !hang) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) fir_ready <= 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each accepted result.
    logic spacing_en   = 1'b0;
    int   last_out_cyc = -1;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got %0h, expected no output", out_data);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (spacing_en && last_out_cyc >= 0)
                check("out_spacing", 32'(cyc - last_out_cyc), 32'd8);
            last_out_cyc = cyc;
        end
    end

    // Start-pulse monitor: count pulses and reject back-to-back starts.
    logic prev_start  = 1'b0;
    int   start_count = 0;
    always @(negedge clk) begin
        if (!rst && fir_start) begin
            start_count++;
            check("start_single_cycle", 32'(prev_start), 32'd0);
        end
        prev_start = fir_start;
    end

    // Driver: hold a sample until accepted, optionally expect its result.
    task automatic push(input logic [OPSIZE-1:0] x, input bit with_exp);
        int n;
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("push_timeout", 32'(n), 32'd0);
        if (with_exp) exp_q.push_back(x + 12'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // One sample into an idle system: checks the issue pulse and latency.
    task automatic single_sample(input logic [OPSIZE-1:0] x);
        int n;
        push(x, 1'b1);
        check("start_after_e0", 32'(fir_start), 32'd0);
        tick();
        check("start_after_e1", 32'(fir_start), 32'd1);
        check("xin_after_e1", 32'(fir_xin), 32'(x));
        tick();
        check("start_after_e2", 32'(fir_start), 32'd0);
        check("xin_after_e2", 32'(fir_xin), 32'(x));
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("latency_e2_to_valid", 32'(n), 32'd6);
        check("single_out_data", 32'(out_data), 32'(x + 12'd1));
        drain(50);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int s0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        hang      = 1'b0;
        stub_kick = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fir_start", 32'(fir_start), 32'd0);
        check("rst_fir_xin", 32'(fir_xin), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Single sample 12'h123.
        single_sample(12'h123);
        check("single_err", 32'(err), 32'd0);
        repeat (3) tick();

        // Burst 1..6 into a 4-deep FIFO.
        spacing_en   = 1'b1;
        last_out_cyc = -1;
        for (int i = 1; i <= 5; i++) push(OPSIZE'(i), 1'b1);
        check("burst_in_ready_full", 32'(in_ready), 32'd0);
        check("burst_count_full", 32'(u_dut.u_fifo.count_q), 32'd4);
        in_valid = 1'b1;
        in_data  = 12'd6;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("full_pop_no_push_count", 32'(u_dut.u_fifo.count_q), 32'd3);
        exp_q.push_back(12'd7);
        tick();
        in_valid = 1'b0;
        drain(200);
        spacing_en = 1'b0;
        repeat (3) tick();

        // Backpressure: hold out_ready low with three samples queued.
        out_ready = 1'b0;
        push(12'h010, 1'b1);
        push(12'h020, 1'b1);
        push(12'h030, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        s0 = start_count;
        repeat (30) tick();
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
        check("bp_out_data_held", 32'(out_data), 32'h011);
        check("bp_no_new_start", 32'(start_count), 32'(s0));
        check("bp_fifo_count", 32'(u_dut.u_fifo.count_q), 32'd2);
        out_ready = 1'b1;
        drain(200);
        repeat (3) tick();

        // Watchdog: FIR never returns ready.
        hang = 1'b1;
        push(12'h007, 1'b0);
        n = 0;
        while (!err && n < 200) begin
            tick();
            n++;
        end
        check("wd_err_latency", 32'(n), 32'd66);
        check("wd_no_out_valid", 32'(out_valid), 32'd0);
        stub_kick = 1'b1;
        tick();
        stub_kick = 1'b0;
        hang      = 1'b0;
        push(12'h055, 1'b1);
        drain(100);
        check("wd_err_sticky", 32'(err), 32'd1);
        repeat (3) tick();

        // Reset while WAITing with two samples queued.
        push(12'h100, 1'b0);
        push(12'h200, 1'b0);
        push(12'h300, 1'b0);
        check("pre_rst_count", 32'(u_dut.u_fifo.count_q), 32'd2);
        rst = 1'b1;
        tick();
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_fir_start", 32'(fir_start), 32'd0);
        check("midrst_count", 32'(u_dut.u_fifo.count_q), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        single_sample(12'hABC);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
